// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word fetches over a valid/ready channel and buffers in-order
// responses in a small FIFO feeding decode. A redirect flushes the buffer and drops stale responses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   shadow_q [MAX_OUTST];
  logic [SW-1:0] sh_wptr_q, sh_rptr_q;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic          pop, accept, push;

  function automatic logic [SW-1:0] sh_inc(input logic [SW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
  endfunction

  assign id_valid      = (count_q != '0);
  assign id_instr      = fifo_instr_q[rptr_q];
  assign id_pc         = fifo_pc_q[rptr_q];
  assign imem_req_addr = fetch_pc_q;
  assign pop           = id_valid && id_ready;

  // An entry leaving to decode this cycle already counts as free space, which is what
  // lets a one-cycle memory sustain one instruction per cycle with a two-entry buffer.
  assign imem_req_valid = (state_q != S_BOOT) && (32'(outst_q) < MAX_OUTST) &&
                          (32'(outst_q) + 32'(count_q) - 32'(pop) < FIFO_DEPTH);
  assign accept = imem_req_valid && imem_req_ready;
  assign push   = imem_resp_valid && (drop_q == '0) && !redirect_valid;

  always_comb begin
    outst_d    = outst_q + OW'(accept) - OW'(imem_resp_valid);
    drop_d     = drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (redirect_valid) begin
      drop_d     = outst_d;
      count_d    = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      sh_wptr_q  <= '0;
      sh_rptr_q  <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
      for (int unsigned i = 0; i < MAX_OUTST; i++) shadow_q[i] <= '0;
    end else begin
      if (redirect_valid) begin
        state_q <= (outst_d != '0) ? S_FLUSH : S_RUN;
      end else begin
        case (state_q)
          S_BOOT:  state_q <= S_RUN;
          S_FLUSH: if (drop_d == '0) state_q <= S_RUN;
          default: state_q <= state_q;
        endcase
      end

      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;

      if (accept) begin
        shadow_q[sh_wptr_q] <= fetch_pc_q;
        sh_wptr_q           <= sh_inc(sh_wptr_q);
      end
      if (imem_resp_valid) sh_rptr_q <= sh_inc(sh_rptr_q);

      if (push) begin
        fifo_instr_q[wptr_q] <= imem_resp_data;
        fifo_pc_q[wptr_q]    <= shadow_q[sh_rptr_q];
      end
      if (redirect_valid) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model plus a stream-level reference
// (expected request and delivery PCs advance by 4 from the last redirect target).
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUTST  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mem_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_req_pc, exp_id_pc;
  int          delivered = 0;
  bit          after_redir, hold_prev;
  logic [31:0] hold_ii, hold_ip;
  bit          resp_en;
  int          resp_pct;
  bit          last_rv, last_iv, last_hs;
  logic [31:0] last_ip, last_ii;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    mem_q.delete();
    acc_log.delete();
    exp_req_pc      = RESET_PC;
    exp_id_pc       = RESET_PC;
    after_redir     = 0;
    hold_prev       = 0;
    imem_resp_valid = 0;
    imem_resp_data  = '0;
    redirect_valid  = 0;
  endtask

  // One clock cycle: drive memory response, check outputs against the stream model, advance.
  task automatic tick();
    logic rsp, acc, hs, rd;
    logic [31:0] rpc;
    rsp = resp_en && (mem_q.size() > 0) && ($urandom_range(99) < resp_pct);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? memfn(mem_q[0]) : '0;
    #1;
    last_rv = imem_req_valid; last_iv = id_valid; last_ip = id_pc; last_ii = id_instr;
    rd  = redirect_valid;
    rpc = redirect_pc;
    acc = imem_req_valid && imem_req_ready;
    hs  = id_valid && id_ready;
    last_hs = hs;
    if (after_redir) begin
      tests++;
      if (id_valid !== 1'b0) begin
        fails++; $display("FAIL id_valid_after_redirect: got %b expected 0", id_valid);
      end
    end
    if (hold_prev) begin
      tests++;
      if (id_valid !== 1'b1 || id_instr !== hold_ii || id_pc !== hold_ip) begin
        fails++;
        $display("FAIL id_hold: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=%h",
                 id_valid, id_instr, id_pc, hold_ii, hold_ip);
      end
    end
    if (imem_req_valid) begin
      tests++;
      if (mem_q.size() >= MAX_OUTST) begin
        fails++; $display("FAIL outst_limit: got %0d in flight with req_valid expected < %0d", mem_q.size(), MAX_OUTST);
      end
    end
    if (acc) begin
      tests++;
      if (imem_req_addr !== exp_req_pc) begin
        fails++; $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_req_pc);
      end
      exp_req_pc += 32'd4;
      acc_log.push_back(imem_req_addr);
      mem_q.push_back(imem_req_addr);
    end
    if (hs) begin
      tests++;
      if (id_pc !== exp_id_pc || id_instr !== memfn(exp_id_pc)) begin
        fails++;
        $display("FAIL id_data: got pc=%h instr=%h expected pc=%h instr=%h",
                 id_pc, id_instr, exp_id_pc, memfn(exp_id_pc));
      end
      exp_id_pc += 32'd4;
      delivered++;
    end
    hold_prev   = id_valid && !id_ready && !rd;
    hold_ii     = id_instr;
    hold_ip     = id_pc;
    after_redir = rd;
    if (rd) begin
      exp_req_pc = rpc & ~32'h3;
      exp_id_pc  = rpc & ~32'h3;
    end
    if (rsp) void'(mem_q.pop_front());
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0; redirect_pc = '0;
    resp_en = 0; resp_pct = 100;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valids: got req=%b id=%b expected 0 0", imem_req_valid, id_valid);
    end
    tests++;
    if (imem_req_addr !== RESET_PC) begin
      fails++; $display("FAIL reset_addr: got %h expected %h", imem_req_addr, RESET_PC);
    end
    tests++;
    if (id_instr !== 32'h0 || id_pc !== 32'h0) begin
      fails++; $display("FAIL reset_id: got instr=%h pc=%h expected 0 0", id_instr, id_pc);
    end
  endtask

  task automatic test_stream();
    int first, valid_cnt;
    logic [31:0] fip;
    imem_req_ready = 1'b1; id_ready = 1'b1; resp_en = 1; resp_pct = 100;
    rst_n = 1'b1;
    first = -1; valid_cnt = 0; fip = 'x;
    for (int k = 0; k < 26; k++) begin
      tick();
      if (last_iv && first < 0) begin first = k; fip = last_ip; end
      if (k >= 3 && last_iv) valid_cnt++;
    end
    tests++;
    if (first != 3) begin fails++; $display("FAIL first_id_latency: got %0d expected 3", first); end
    tests++;
    if (fip !== RESET_PC) begin fails++; $display("FAIL first_id_pc: got %h expected %h", fip, RESET_PC); end
    tests++;
    if (valid_cnt != 23) begin fails++; $display("FAIL stream_rate: got %0d expected 23", valid_cnt); end
  endtask

  task automatic test_backpressure();
    int d0;
    id_ready = 1'b0;
    repeat (10) tick();
    tests++;
    if (last_rv !== 1'b0) begin fails++; $display("FAIL stall_req_valid: got %b expected 0", last_rv); end
    tests++;
    if (mem_q.size() != 0) begin fails++; $display("FAIL stall_in_flight: got %0d expected 0", mem_q.size()); end
    tests++;
    if (exp_req_pc - exp_id_pc !== 32'(4 * FIFO_DEPTH)) begin
      fails++; $display("FAIL stall_buffered: got %0d expected %0d", (exp_req_pc - exp_id_pc) / 4, FIFO_DEPTH);
    end
    id_ready = 1'b1;
    d0 = delivered;
    repeat (10) tick();
    tests++;
    if (delivered - d0 != 10) begin fails++; $display("FAIL drain_count: got %0d expected 10", delivered - d0); end
  endtask

  task automatic test_redirect_drop();
    bit got;
    do_reset();
    imem_req_ready = 1'b0; resp_en = 0; id_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    imem_req_ready = 1'b1;
    repeat (3) tick();
    tests++;
    if (mem_q.size() != 2 || acc_log.size() != 2) begin
      fails++; $display("FAIL drop_setup: got %0d in flight expected 2", mem_q.size());
    end else begin
      tests++;
      if (acc_log[0] !== 32'h10 || acc_log[1] !== 32'h14) begin
        fails++; $display("FAIL drop_setup_addr: got %h %h expected 00000010 00000014", acc_log[0], acc_log[1]);
      end
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    resp_en = 1; resp_pct = 100; imem_req_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (last_hs && !got) begin
        got = 1;
        tests++;
        if (last_ip !== 32'h100 || last_ii !== memfn(32'h100)) begin
          fails++; $display("FAIL redirect_target: got pc=%h instr=%h expected pc=00000100 instr=%h",
                            last_ip, last_ii, memfn(32'h100));
        end
      end
    end
    if (!got) begin tests++; fails++; $display("FAIL redirect_timeout: got no delivery expected pc=00000100"); end
  endtask

  task automatic test_redirect_collide();
    bit done;
    int d0;
    resp_pct = 100; imem_req_ready = 1'b1; id_ready = 1'b1; resp_en = 1;
    repeat (5) tick();
    done = 0;
    for (int k = 0; k < 20; k++) begin
      if (!done && id_valid === 1'b1 && mem_q.size() > 0) begin
        redirect_valid = 1'b1; redirect_pc = 32'h2000;
        d0 = delivered;
        tick();
        tests++;
        if (delivered != d0 + 1) begin fails++; $display("FAIL collide_consumed: got %0d expected 1", delivered - d0); end
        tick();
        tests++;
        if (last_iv !== 1'b0) begin fails++; $display("FAIL collide_id_valid: got %b expected 0", last_iv); end
        done = 1;
      end else if (!done) begin
        tick();
      end
    end
    tests++;
    if (!done) begin fails++; $display("FAIL collide_setup: got no collision cycle expected one"); end
    repeat (8) tick();
    tests++;
    if (exp_id_pc < 32'h200C || exp_id_pc > 32'h2100) begin
      fails++; $display("FAIL collide_progress: got next pc %h expected >= 0000200c", exp_id_pc);
    end
  endtask

  task automatic test_wrap();
    int idx;
    acc_log.delete();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    repeat (9) tick();
    idx = -1;
    foreach (acc_log[i]) if (idx < 0 && acc_log[i] === 32'hFFFF_FFFC) idx = i;
    tests++;
    if (idx < 0 || idx + 1 >= acc_log.size()) begin
      fails++; $display("FAIL wrap_seen: got %0d requests expected fffffffc then 00000000", acc_log.size());
    end else if (acc_log[idx+1] !== 32'h0) begin
      fails++; $display("FAIL wrap_addr: got %h expected 00000000", acc_log[idx+1]);
    end
  endtask

  task automatic test_async_reset();
    id_ready = 1'b0;
    repeat (8) tick();
    tests++;
    if (last_iv !== 1'b1) begin fails++; $display("FAIL prereset_full: got id_valid=%b expected 1", last_iv); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL async_reset: got id=%b req=%b expected 0 0", id_valid, imem_req_valid);
    end
    tests++;
    if (imem_req_addr !== RESET_PC) begin
      fails++; $display("FAIL async_reset_addr: got %h expected %h", imem_req_addr, RESET_PC);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; id_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (10) tick();
    tests++;
    if (acc_log.size() == 0 || acc_log[0] !== RESET_PC) begin
      fails++; $display("FAIL restart_addr: got %0d requests expected first at %h", acc_log.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    int d0;
    resp_pct = 60;
    for (int k = 0; k < 1500; k++) begin
      imem_req_ready = ($urandom_range(99) < 70);
      id_ready       = ($urandom_range(99) < 65);
      if ($urandom_range(99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      tick();
    end
    imem_req_ready = 1'b1; id_ready = 1'b1; resp_pct = 100;
    d0 = delivered;
    repeat (20) tick();
    tests++;
    if (delivered - d0 < 10) begin fails++; $display("FAIL random_drain: got %0d delivered expected >= 10", delivered - d0); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
